// File: rtl/ucode_pkg.sv
// ucode_pkg: opcodes, condition codes, microword layout and FSM states shared by the sequencer and its ROM.
package ucode_pkg;
  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP = 3'd1;
  localparam logic [2:0] OP_BR = 3'd2;
  localparam logic [2:0] OP_LDC = 3'd3;
  localparam logic [2:0] OP_DJNZ = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd7;
  localparam logic [1:0] C_X1 = 2'd0;
  localparam logic [1:0] C_X2 = 2'd1;
  localparam logic [1:0] C_NX1 = 2'd2;
  localparam logic [1:0] C_NX2 = 2'd3;
  localparam int OUT_BIT = 11;
  localparam int OP_HI = 10;
  localparam int OP_LO = 8;
  localparam int TGT_HI = 7;
  localparam int TGT_LO = 4;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  function automatic logic [11:0] uword(input logic o, input logic [2:0] op, input logic [3:0] tgt, input logic [3:0] imm);
    return {o, op, tgt, imm};
  endfunction
endpackage

// File: rtl/ucode_rom.sv
// ucode_rom: combinational 16x12 control store holding the default microprogram.
module ucode_rom
  import ucode_pkg::*;
(
  input  logic [3:0]  addr,
  output logic [11:0] word
);
  always_comb
    case (addr)
      4'd0:    word = uword(1'b0, OP_NEXT, 4'd0, 4'd0);
      4'd1:    word = uword(1'b1, OP_BR, 4'd4, {2'b00, C_X1});
      4'd2:    word = uword(1'b0, OP_NEXT, 4'd0, 4'd0);
      4'd3:    word = uword(1'b1, OP_JMP, 4'd7, 4'd0);
      4'd4:    word = uword(1'b0, OP_NEXT, 4'd0, 4'd0);
      4'd5:    word = uword(1'b1, OP_BR, 4'd4, {2'b00, C_NX2});
      4'd6:    word = uword(1'b0, OP_JMP, 4'd8, 4'd0);
      4'd7:    word = uword(1'b1, OP_NEXT, 4'd0, 4'd0);
      4'd9:    word = uword(1'b0, OP_LDC, 4'd0, 4'd3);
      4'd10:   word = uword(1'b1, OP_DJNZ, 4'd10, 4'd0);
      default: word = uword(1'b0, OP_HALT, 4'd0, 4'd0);
    endcase
endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: start/busy/done launched sequencer stepping a 16-word control store,
// with qualifier branches, a loop counter and a step watchdog.
module microcode_sequencer
  import ucode_pkg::*;
#(
  parameter logic [3:0] START_ADDR = 4'd0,
  parameter int         MAX_STEPS  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       x1,
  input  logic       x2,
  output logic       out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] pc
);
  localparam logic [7:0] LAST_STEP = 8'(MAX_STEPS - 1);
  state_t state, state_n;
  logic [11:0] word;
  logic [2:0] op;
  logic [3:0] tgt, imm, cnt, cnt_n, cnt_dec, pc_n, pc_inc;
  logic [7:0] steps;
  logic cond, halt, wd;
  ucode_rom rom (.addr(pc), .word(word));
  assign op = word[OP_HI:OP_LO];
  assign tgt = word[TGT_HI:TGT_LO];
  assign imm = word[IMM_HI:IMM_LO];
  assign pc_inc = pc + 4'd1;
  assign cnt_dec = cnt - 4'd1;
  assign halt = op == OP_HALT;
  assign wd = steps == LAST_STEP;
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  assign out = busy & word[OUT_BIT];
  always_comb begin
    cond = imm[1:0] == C_X1 ? x1 : imm[1:0] == C_X2 ? x2 : imm[1:0] == C_NX1 ? !x1 : !x2;
    pc_n = op == OP_JMP ? tgt :
           op == OP_BR ? (cond ? tgt : pc_inc) :
           op == OP_DJNZ ? (cnt_dec != 4'd0 ? tgt : pc_inc) :
           halt ? pc : pc_inc;
    cnt_n = op == OP_LDC ? imm : op == OP_DJNZ ? cnt_dec : cnt;
    state_n = state == S_IDLE ? (start ? S_RUN : S_IDLE) :
              state == S_RUN ? (halt || wd ? S_DONE : S_RUN) : S_IDLE;
  end
  // HALT outranks the watchdog, so a HALT on the last allowed step completes cleanly
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      pc <= START_ADDR;
      cnt <= 4'd0;
      steps <= 8'd0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        pc <= START_ADDR;
        cnt <= 4'd0;
        steps <= 8'd0;
        err <= 1'b0;
      end else if (state == S_RUN) begin
        pc <= pc_n;
        cnt <= cnt_n;
        steps <= steps + 8'd1;
        err <= !halt && wd;
      end
    end
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: three sequencer variants driven by fixed and random qualifier streams,
// checked against an instruction-level interpreter of the microprogram.
module tb_microcode_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] start = '0;
  logic x1 = 1'b0, x2 = 1'b0;
  logic [2:0] o_out, o_busy, o_done, o_err;
  logic [2:0][3:0] o_pc;
  int checks = 0, fails = 0;
  int r_out[16] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
  int r_op[16]  = '{0, 2, 0, 1, 0, 2, 1, 0, 7, 3, 4, 7, 7, 7, 7, 7};
  int r_tgt[16] = '{0, 4, 0, 7, 0, 4, 8, 0, 0, 0, 10, 0, 0, 0, 0, 0};
  int r_imm[16] = '{0, 0, 0, 0, 0, 3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0};
  int cap_pc[$], cap_out[$], exp_pc[$], exp_out[$];
  bit xq1[$], xq2[$];
  int n_done, overlap;
  bit tmo, err_done, out_done, post_busy, post_done, err_after, err_run, exp_err, gx1, gx2;

  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  microcode_sequencer u0 (.clk(clk), .reset(reset), .start(start[0]), .x1(x1), .x2(x2),
    .out(o_out[0]), .busy(o_busy[0]), .done(o_done[0]), .err(o_err[0]), .pc(o_pc[0]));
  microcode_sequencer #(.START_ADDR(4'd9)) u1 (.clk(clk), .reset(reset), .start(start[1]), .x1(x1), .x2(x2),
    .out(o_out[1]), .busy(o_busy[1]), .done(o_done[1]), .err(o_err[1]), .pc(o_pc[1]));
  microcode_sequencer #(.MAX_STEPS(8)) u2 (.clk(clk), .reset(reset), .start(start[2]), .x1(x1), .x2(x2),
    .out(o_out[2]), .busy(o_busy[2]), .done(o_done[2]), .err(o_err[2]), .pc(o_pc[2]));

  // Launch instance d with a one-cycle start pulse and record every busy cycle plus the completion.
  // xmode: 0 random qualifiers, 1 fixed gx1/gx2, 2 x1=1 with x2 low for the first nine steps.
  task automatic run_capture(input int d, input int xmode);
    int cyc;
    bit fin;
    cap_pc.delete(); cap_out.delete(); xq1.delete(); xq2.delete();
    n_done = 0; overlap = 0; tmo = 0; err_done = 0; out_done = 0; err_run = 0;
    @(negedge clk); start[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0;
    cyc = 0; fin = 0;
    while (!fin && cyc < 400) begin
      if (o_busy[d] && o_done[d]) overlap++;
      if (o_busy[d]) begin
        cap_pc.push_back(int'(o_pc[d]));
        cap_out.push_back(int'(o_out[d]));
        err_run |= o_err[d];
        x1 = xmode == 0 ? 1'($urandom_range(0, 1)) : xmode == 1 ? gx1 : 1'b1;
        x2 = xmode == 0 ? 1'($urandom_range(0, 1)) : xmode == 1 ? gx2 : 1'(cyc >= 9);
        xq1.push_back(x1);
        xq2.push_back(x2);
      end else begin
        if (o_done[d]) begin
          n_done++;
          err_done = o_err[d];
          out_done = o_out[d];
        end
        fin = 1;
      end
      @(negedge clk);
      cyc++;
    end
    tmo = !fin;
    post_busy = o_busy[d];
    post_done = o_done[d];
    err_after = o_err[d];
  endtask

  // Interpreter of the microprogram at instruction level, replaying the recorded qualifiers.
  task automatic ref_model(input int saddr, input int maxs);
    int pc, cnt, nxt, c;
    bit a1, a2, cv;
    exp_pc.delete(); exp_out.delete();
    pc = saddr; cnt = 0; exp_err = 0;
    for (int s = 1; s <= 255; s++) begin
      exp_pc.push_back(pc);
      exp_out.push_back(r_out[pc]);
      if (r_op[pc] == 7) break;
      a1 = s - 1 < xq1.size() ? xq1[s-1] : 1'b0;
      a2 = s - 1 < xq2.size() ? xq2[s-1] : 1'b0;
      c = r_imm[pc] % 4;
      cv = c == 0 ? a1 : c == 1 ? a2 : c == 2 ? !a1 : !a2;
      nxt = (pc + 1) % 16;
      case (r_op[pc])
        1: nxt = r_tgt[pc];
        2: nxt = cv ? r_tgt[pc] : nxt;
        3: cnt = r_imm[pc];
        4: begin
          cnt = (cnt + 15) % 16;
          nxt = cnt != 0 ? r_tgt[pc] : nxt;
        end
        default: ;
      endcase
      if (s == maxs) begin
        exp_err = 1;
        break;
      end
      pc = nxt;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_busy[d] !== 1'b0 || o_done[d] !== 1'b0 || o_err[d] !== 1'b0 || o_out[d] !== 1'b0 || o_pc[d] !== (d == 1 ? 4'd9 : 4'd0)) begin
        fails++;
        $display("FAIL reset_u%0d busy=%0b done=%0b err=%0b out=%0b pc=%0d exp 0 0 0 0 %0d", d, o_busy[d], o_done[d], o_err[d], o_out[d], o_pc[d], d == 1 ? 9 : 0);
      end
    end
  endtask

  task automatic test_sequences();
    string nm;
    int d, m;
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin nm = "path_x1"; d = 0; m = 1; gx1 = 1; gx2 = 1; exp_err = 0;
          exp_pc = '{0, 1, 4, 5, 6, 8}; exp_out = '{0, 1, 0, 1, 0, 0}; end
        1: begin nm = "path_nx1"; d = 0; m = 1; gx1 = 0; gx2 = 1; exp_err = 0;
          exp_pc = '{0, 1, 2, 3, 7, 8}; exp_out = '{0, 1, 0, 1, 1, 0}; end
        2: begin nm = "loop3"; d = 0; m = 2; exp_err = 0;
          exp_pc = '{0, 1, 4, 5, 4, 5, 4, 5, 4, 5, 6, 8}; exp_out = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0}; end
        3: begin nm = "djnz"; d = 1; m = 0; exp_err = 0;
          exp_pc = '{9, 10, 10, 10, 11}; exp_out = '{0, 1, 1, 1, 0}; end
        default: begin nm = "watchdog"; d = 2; m = 1; gx1 = 1; gx2 = 0; exp_err = 1;
          exp_pc = '{0, 1, 4, 5, 4, 5, 4, 5}; exp_out = '{0, 1, 0, 1, 0, 1, 0, 1}; end
      endcase
      run_capture(d, m);
      checks++;
      if (tmo || cap_pc.size() != exp_pc.size()) begin
        fails++;
        $display("FAIL %s_len busy_cycles=%0d exp=%0d timeout=%0b", nm, cap_pc.size(), exp_pc.size(), tmo);
      end
      foreach (exp_pc[i]) if (i < cap_pc.size()) begin
        checks++;
        if (cap_pc[i] != exp_pc[i] || cap_out[i] != exp_out[i]) begin
          fails++;
          $display("FAIL %s_step%0d pc=%0d out=%0d exp pc=%0d out=%0d", nm, i, cap_pc[i], cap_out[i], exp_pc[i], exp_out[i]);
        end
      end
      checks++;
      if (n_done != 1 || overlap != 0 || err_done != exp_err || err_after != exp_err || out_done || post_busy || post_done || err_run) begin
        fails++;
        $display("FAIL %s_end done_pulses=%0d overlap=%0d err=%0b err_idle=%0b out=%0b post_busy=%0b post_done=%0b err_run=%0b exp 1 0 %0b %0b 0 0 0 0",
          nm, n_done, overlap, err_done, err_after, out_done, post_busy, post_done, err_run, exp_err, exp_err);
      end
    end
  endtask

  task automatic test_watchdog_clear();
    repeat (3) @(negedge clk);
    checks++;
    if (o_err[2] !== 1'b1) begin
      fails++;
      $display("FAIL err_hold got=%0b exp=1", o_err[2]);
    end
    gx1 = 0; gx2 = 1;
    run_capture(2, 1);
    checks++;
    if (err_run || err_done || cap_pc.size() != 6 || n_done != 1) begin
      fails++;
      $display("FAIL err_clear err_run=%0b err_done=%0b busy_cycles=%0d done_pulses=%0d exp 0 0 6 1", err_run, err_done, cap_pc.size(), n_done);
    end
  endtask

  task automatic test_random();
    int d;
    for (int k = 0; k < 15; k++) begin
      d = k % 3;
      run_capture(d, 0);
      ref_model(d == 1 ? 9 : 0, d == 2 ? 8 : 64);
      checks++;
      if (tmo || cap_pc.size() != exp_pc.size()) begin
        fails++;
        $display("FAIL rand%0d_len busy_cycles=%0d exp=%0d timeout=%0b", k, cap_pc.size(), exp_pc.size(), tmo);
      end
      foreach (exp_pc[i]) if (i < cap_pc.size()) begin
        checks++;
        if (cap_pc[i] != exp_pc[i] || cap_out[i] != exp_out[i]) begin
          fails++;
          $display("FAIL rand%0d_step%0d pc=%0d out=%0d exp pc=%0d out=%0d", k, i, cap_pc[i], cap_out[i], exp_pc[i], exp_out[i]);
        end
      end
      checks++;
      if (n_done != 1 || overlap != 0 || err_done != exp_err || out_done || post_busy || post_done) begin
        fails++;
        $display("FAIL rand%0d_end done_pulses=%0d overlap=%0d err=%0b out=%0b post_busy=%0b post_done=%0b exp 1 0 %0b 0 0 0",
          k, n_done, overlap, err_done, out_done, post_busy, post_done, exp_err);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int ep;
    x1 = 1'b1; x2 = 1'b0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ep = i < 2 ? i : (i % 2 == 0 ? 4 : 5);
      checks++;
      if (o_busy[0] !== 1'b1 || o_done[0] !== 1'b0 || o_pc[0] !== 4'(ep)) begin
        fails++;
        $display("FAIL ignore_start%0d busy=%0b done=%0b pc=%0d exp 1 0 %0d", i, o_busy[0], o_done[0], o_pc[0], ep);
      end
      start[0] = i == 4;
      @(negedge clk);
    end
    start[0] = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (o_busy[0] !== 1'b0 || o_done[0] !== 1'b0 || o_out[0] !== 1'b0 || o_err[0] !== 1'b0 || o_pc[0] !== 4'd0) begin
      fails++;
      $display("FAIL async_reset busy=%0b done=%0b out=%0b err=%0b pc=%0d exp 0 0 0 0 0", o_busy[0], o_done[0], o_out[0], o_err[0], o_pc[0]);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_busy[0] !== 1'b0 || o_done[0] !== 1'b0) begin
        fails++;
        $display("FAIL post_reset%0d busy=%0b done=%0b exp 0 0", i, o_busy[0], o_done[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit eb, ed;
    x1 = 1'b1; x2 = 1'b1;
    @(negedge clk); start[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      eb = (i < 6) || (i >= 8 && i < 14);
      ed = (i == 6) || (i == 14);
      checks++;
      if (o_busy[0] !== eb || o_done[0] !== ed) begin
        fails++;
        $display("FAIL b2b_cycle%0d busy=%0b done=%0b exp %0b %0b", i, o_busy[0], o_done[0], eb, ed);
      end
      if (i == 14) start[0] = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_sequences();
    test_watchdog_clear();
    test_random();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
